// File: rtl/pulse_tx.sv
// Shaped pulse transmitter: turns queued single-cycle requests into HIGH_TIME-wide
// pulses separated by at least LOW_TIME low cycles. Optional flush port: PULSE_TX_FLUSH_EN.
module pulse_tx #(
  parameter int HIGH_TIME   = 10,
  parameter int LOW_TIME    = 10,
  parameter int MAX_PENDING = 15,
  parameter int CNT_W       = 32,
  localparam int PEND_W     = $clog2(MAX_PENDING + 1)
) (
  input  logic              clk,
  input  logic              reset,
`ifdef PULSE_TX_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              req_valid,
  output logic              req_ready,
  output logic              o,
  output logic              busy,
  output logic [PEND_W-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam logic [CNT_W-1:0]  HIGH_LAST = CNT_W'(HIGH_TIME - 1);
  localparam logic [CNT_W-1:0]  LOW_LAST  = CNT_W'(LOW_TIME - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              o_next;
  logic [PEND_W-1:0] pending_next;
  logic              flush_i;
  logic              accept;
  logic              gap_done;
  logic              start;

`ifdef PULSE_TX_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign req_ready = (pending < PEND_MAX) && !flush_i;
  assign accept    = req_valid && req_ready;
  assign gap_done  = (state == LOW) && (cnt == LOW_LAST);
  // A flushed queue must not launch a new pulse; an in-flight pulse and its gap still run out.
  assign start     = ((state == IDLE) || gap_done) && ((pending != '0) || accept) && !flush_i;
  assign busy      = (state != IDLE) || (pending != '0);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    state_next = state;
    cnt_next   = cnt;
    o_next     = o;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = HIGH;
          cnt_next   = '0;
          o_next     = 1'b1;
        end
      end
      HIGH: begin
        if (cnt == HIGH_LAST) begin
          state_next = LOW;
          cnt_next   = '0;
          o_next     = 1'b0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      LOW: begin
        if (gap_done) begin
          cnt_next   = '0;
          state_next = start ? HIGH : IDLE;
          o_next     = start;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        o_next     = 1'b0;
      end
    endcase
  end

  // Start consumes a queued request first, or the same-cycle accept when the queue is empty.
  always_comb begin
    pending_next = pending;
    if (flush_i)
      pending_next = '0;
    else if (accept && !start)
      pending_next = pending + PEND_W'(1);
    else if (!accept && start)
      pending_next = pending - PEND_W'(1);
  end

  // o has its own flop so the pad sees a clean registered edge, not a state decode.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      o       <= 1'b0;
      pending <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      o       <= o_next;
      pending <= pending_next;
    end
  end

endmodule

// File: tb/tb_pulse_tx.sv
// Self-checking bench for pulse_tx: a timeline model (start times, queue depth) checked
// every cycle, plus directed sequences with hand-computed expectations.
module tb_pulse_tx;
  localparam int HT = 4;
  localparam int LT = 3;
  localparam int MP = 2;
  localparam int PW = $clog2(MP + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          flush = 1'b0;
  logic          req_ready;
  logic          o;
  logic          busy;
  logic [PW-1:0] pending;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pulse_tx #(
    .HIGH_TIME  (HT),
    .LOW_TIME   (LT),
    .MAX_PENDING(MP),
    .CNT_W      (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef PULSE_TX_FLUSH_EN
    .flush    (flush),
`endif
    .req_valid(req_valid),
    .req_ready(req_ready),
    .o        (o),
    .busy     (busy),
    .pending  (pending)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0d want=%0d", name, $time, act, exp);
    end
  endtask

  // Timeline model: a pulse started at edge s is high after edges s..s+HT-1,
  // and the next pulse may start no earlier than edge s+HT+LT.
  int t = 0;
  bit have_pulse = 0;
  int last_start = 0;
  int pend_m = 0;
  int starts_m = 0;
  bit seen_edge = 0;
  bit acc_m, can_m, st_m;

  always @(posedge clk) begin
    t++;
    seen_edge = 1;
    if (reset) begin
      have_pulse = 0;
      pend_m = 0;
    end else begin
      acc_m = req_valid && (pend_m < MP) && !flush;
      can_m = !have_pulse || (t >= last_start + HT + LT);
      st_m  = can_m && !flush && (pend_m > 0 || acc_m);
      if (st_m) begin
        have_pulse = 1;
        last_start = t;
        starts_m++;
      end
      pend_m = flush ? 0 : pend_m + int'(acc_m) - int'(st_m);
    end
  end

  int rises = 0;
  logic o_prev = 1'b0;
  logic exp_o, exp_busy, exp_ready;

  always @(negedge clk) begin
    if (seen_edge) begin
      exp_o     = have_pulse && (t - last_start < HT);
      exp_busy  = (pend_m != 0) || (have_pulse && (t < last_start + HT + LT));
      exp_ready = (pend_m < MP) && !flush;
      check("o", 32'(o), 32'(exp_o));
      check("busy", 32'(busy), 32'(exp_busy));
      check("pending", 32'(pending), 32'(pend_m));
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      if (o === 1'b1 && o_prev === 1'b0) rises++;
      o_prev = o;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_o", 32'(o), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_ready", 32'(req_ready), 1);

    // Single accept from idle: high 4 cycles, low after, idle 7 cycles after the accept edge.
    step();
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("single_o", 32'(o), (k < HT) ? 1 : 0);
      check("single_busy", 32'(busy), (k < HT + LT) ? 1 : 0);
      check("single_pending", 32'(pending), 0);
    end

    // Request accepted on the edge that ends the gap: back-to-back with exactly LT low cycles.
    step();
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (6) step();
    req_valid = 1'b1;
    @(negedge clk);
    check("lastgap_o_low", 32'(o), 0);
    check("lastgap_busy", 32'(busy), 1);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check("lastgap_o_high", 32'(o), 1);
    check("lastgap_pending", 32'(pending), 0);
    repeat (12) step();

    // Three consecutive requests from idle.
    req_valid = 1'b1;
    repeat (3) step();
    req_valid = 1'b0;
    @(negedge clk);
    check("burst_pending", 32'(pending), 2);
    repeat (25) step();

    // Held request: queue fills to MP and back-pressures.
    req_valid = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("full_ready", 32'(req_ready), 0);
    repeat (37) step();
    req_valid = 1'b0;
    repeat (30) step();

    // Reset mid-pulse with a full queue.
    req_valid = 1'b1;
    repeat (3) step();
    req_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_o", 32'(o), 0);
    check("midrst_pending", 32'(pending), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_ready", 32'(req_ready), 1);
    for (int k = 0; k < 10; k++) begin
      step();
      @(negedge clk);
      check("midrst_quiet", 32'(o), 0);
    end

`ifdef PULSE_TX_FLUSH_EN
    // Flush during HIGH: current pulse and its gap finish, queue is dropped.
    req_valid = 1'b1;
    repeat (3) step();
    req_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (12) step();
    @(negedge clk);
    check("flush_busy", 32'(busy), 0);
    check("flush_pending", 32'(pending), 0);
`endif

    // Randomized traffic with occasional reset (and flush when present).
    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(0, 99) < 40);
      reset     = ($urandom_range(0, 499) == 0);
`ifdef PULSE_TX_FLUSH_EN
      flush     = ($urandom_range(0, 99) < 3);
`endif
      step();
    end
    req_valid = 1'b0;
    reset = 1'b0;
    flush = 1'b0;
    repeat (30) step();
    @(negedge clk);
    #1;
    check("pulse_count", 32'(rises), 32'(starts_m));
    check("drained_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
